spi_slave_rx: RTL and testbench

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_slave_rx.sv | 195 +++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: synchronizes cs/sck/mosi into clk, receives bytes into an
// RX FIFO and shifts TX FIFO bytes (or IDLE_BYTE) out on miso, MSB first.
module spi_slave_rx #(
  parameter logic [7:0] IDLE_BYTE   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cs,
  input  logic       i_sck,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_miso_oe,
  input  logic [7:0] i_din,
  input  logic       i_tx_fifo_empty,
  output logic       o_tx_fifo_rd,
  output logic [7:0] o_dout,
  input  logic       i_rx_fifo_full,
  output logic       o_rx_fifo_wr,
  input  logic       i_clr_err,
  output logic       o_overrun,
  output logic       o_underrun,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_NEXT
  } state_t;

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;

  logic r_cs_d;
  logic r_sck_d;
  logic r_cs_fall;
  logic r_cs_rise;
  logic r_sck_rise;
  logic r_sck_fall;
  logic r_mosi_d;

  logic w_cs_s;
  logic w_sck_s;
  logic w_mosi_s;

  state_t     r_state;
  logic [7:0] r_tx_shift;
  logic [7:0] r_rx_shift;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_dout;
  logic       r_tx_rd;
  logic       r_rx_wr;
  logic       r_overrun;
  logic       r_underrun;
  logic       r_busy;
  logic       r_miso_oe;

  logic [7:0] w_rx_byte;

  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cs_sync   <= '1;
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
    end
  end

  // Edge pulses are registered; mosi is delayed alongside so it lines up with them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cs_d     <= 1'b1;
      r_sck_d    <= 1'b0;
      r_cs_fall  <= 1'b0;
      r_cs_rise  <= 1'b0;
      r_sck_rise <= 1'b0;
      r_sck_fall <= 1'b0;
      r_mosi_d   <= 1'b0;
    end else begin
      r_cs_d     <= w_cs_s;
      r_sck_d    <= w_sck_s;
      r_cs_fall  <= r_cs_d & ~w_cs_s;
      r_cs_rise  <= ~r_cs_d & w_cs_s;
      r_sck_rise <= ~r_sck_d & w_sck_s;
      r_sck_fall <= r_sck_d & ~w_sck_s;
      r_mosi_d   <= w_mosi_s;
    end
  end

  assign w_rx_byte = {r_rx_shift[6:0], r_mosi_d};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_tx_shift <= 8'h00;
      r_rx_shift <= 8'h00;
      r_bit_cnt  <= 3'd0;
      r_dout     <= 8'h00;
      r_tx_rd    <= 1'b0;
      r_rx_wr    <= 1'b0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
      r_busy     <= 1'b0;
      r_miso_oe  <= 1'b0;
    end else begin
      r_tx_rd <= 1'b0;
      r_rx_wr <= 1'b0;
      // Set events assigned later in this block override the clear.
      if (i_clr_err) begin
        r_overrun  <= 1'b0;
        r_underrun <= 1'b0;
      end
      if (r_cs_rise) begin
        r_state    <= ST_IDLE;
        r_bit_cnt  <= 3'd0;
        r_rx_shift <= 8'h00;
        r_busy     <= 1'b0;
        r_miso_oe  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_cs_fall) begin
              r_state   <= ST_LOAD;
              r_busy    <= 1'b1;
              r_miso_oe <= 1'b1;
            end
          end
          ST_LOAD: begin
            r_state <= ST_SHIFT;
            if (i_tx_fifo_empty) begin
              r_tx_shift <= IDLE_BYTE;
              r_underrun <= 1'b1;
            end else begin
              r_tx_shift <= i_din;
              r_tx_rd    <= 1'b1;
            end
          end
          ST_SHIFT: begin
            if (r_sck_rise) begin
              r_rx_shift <= w_rx_byte;
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_state <= ST_NEXT;
                if (i_rx_fifo_full) begin
                  r_overrun <= 1'b1;
                end else begin
                  r_rx_wr <= 1'b1;
                  r_dout  <= w_rx_byte;
                end
              end
            end else if (r_sck_fall) begin
              r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end
          end
          ST_NEXT: begin
            // Reload on the trailing edge of bit 8 so the next MSB is ready.
            if (r_sck_fall) begin
              r_state <= ST_SHIFT;
              if (i_tx_fifo_empty) begin
                r_tx_shift <= IDLE_BYTE;
                r_underrun <= 1'b1;
              end else begin
                r_tx_shift <= i_din;
                r_tx_rd    <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_miso       = r_tx_shift[7];
  assign o_miso_oe    = r_miso_oe;
  assign o_tx_fifo_rd = r_tx_rd;
  assign o_rx_fifo_wr = r_rx_wr;
  assign o_dout       = r_dout;
  assign o_overrun    = r_overrun;
  assign o_underrun   = r_underrun;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Randomized frame-level bench for spi_slave_rx: bench-side FIFOs plus an
// SPI master, with expected bytes and flags derived per frame.
module tb_spi_slave_rx;

  localparam int         SYNC = 2;
  localparam logic [7:0] IDLE = 8'hFF;

  logic       clk;
  logic       rst_n;
  logic       cs;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] din;
  logic       tx_empty;
  logic       tx_rd;
  logic [7:0] dout;
  logic       rx_full;
  logic       rx_wr;
  logic       clr_err;
  logic       overrun;
  logic       underrun;
  logic       busy;

  spi_slave_rx #(.IDLE_BYTE(IDLE), .SYNC_STAGES(SYNC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cs(cs), .i_sck(sck), .i_mosi(mosi),
    .o_miso(miso), .o_miso_oe(miso_oe), .i_din(din), .i_tx_fifo_empty(tx_empty),
    .o_tx_fifo_rd(tx_rd), .o_dout(dout), .i_rx_fifo_full(rx_full),
    .o_rx_fifo_wr(rx_wr), .i_clr_err(clr_err), .o_overrun(overrun),
    .o_underrun(underrun), .o_busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int tx_rd_cnt = 0;
  int rx_wr_cnt = 0;
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;

  logic [7:0] tx_q[$];
  logic [7:0] exp_rx_q[$];
  int         rise_cyc_q[$];

  logic [7:0] m_bytes[8];
  logic       m_drop[8];
  logic [7:0] tx_vals[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bench-side FIFOs: TX is first-word-fall-through, RX is a scoreboard.
  always @(negedge clk) begin
    if (tx_rd) begin
      tx_rd_cnt++;
      check_eq("tx_rd_width", {31'd0, prev_rd}, 0);
      if (tx_q.size() > 0) void'(tx_q.pop_front());
    end
    if (rx_wr) begin
      rx_wr_cnt++;
      check_eq("rx_wr_width", {31'd0, prev_wr}, 0);
      if (exp_rx_q.size() == 0) begin
        check_eq("rx_wr_unexpected", exp_rx_q.size(), 1);
      end else begin
        check_eq("dout", {24'd0, dout}, {24'd0, exp_rx_q.pop_front()});
        if (rise_cyc_q.size() > 0)
          check_eq("rx_latency", cyc - rise_cyc_q.pop_front(), SYNC + 2);
        $display("[TB] rx_wr dout=%02h at cycle %0d", dout, cyc);
      end
    end
    prev_rd  = tx_rd;
    prev_wr  = rx_wr;
    din      = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    tx_empty = (tx_q.size() == 0);
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_miso"},     {31'd0, miso}, 0);
    check_eq({tag, "_miso_oe"},  {31'd0, miso_oe}, 0);
    check_eq({tag, "_tx_rd"},    {31'd0, tx_rd}, 0);
    check_eq({tag, "_rx_wr"},    {31'd0, rx_wr}, 0);
    check_eq({tag, "_dout"},     {24'd0, dout}, 0);
    check_eq({tag, "_overrun"},  {31'd0, overrun}, 0);
    check_eq({tag, "_underrun"}, {31'd0, underrun}, 0);
    check_eq({tag, "_busy"},     {31'd0, busy}, 0);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    wait_clk(1);
    clr_err = 1'b0;
    wait_clk(1);
    check_eq("clr_overrun",  {31'd0, overrun}, 0);
    check_eq("clr_underrun", {31'd0, underrun}, 0);
  endtask

  // mode 0: complete frame of nb bytes; mode 1: cs abort after stop_bits;
  // mode 2: reset asserted after stop_bits. stop_bits must be below 8.
  task automatic run_frame(input int nb, input int ntx, input int mode, input int stop_bits);
    int rd0, wr0, total, exp_rd, exp_wr, b, k;
    logic exp_ur, exp_or;
    logic [7:0] got;
    tx_q.delete();
    for (int i = 0; i < ntx; i++) tx_q.push_back(tx_vals[i]);
    wait_clk(2);
    rd0 = tx_rd_cnt;
    wr0 = rx_wr_cnt;
    exp_wr = 0;
    exp_or = 1'b0;
    if (mode == 0) begin
      total  = nb * 8;
      exp_rd = (nb < ntx) ? nb : ntx;
      exp_ur = (nb > ntx);
      for (int i = 0; i < nb; i++) begin
        if (m_drop[i]) exp_or = 1'b1;
        else begin
          exp_rx_q.push_back(m_bytes[i]);
          exp_wr++;
        end
      end
    end else begin
      total  = stop_bits;
      exp_rd = (ntx > 0) ? 1 : 0;
      exp_ur = (mode == 1) && (ntx == 0);
    end
    got = 8'h00;
    cs = 1'b0;
    wait_clk(8);
    for (int t = 0; t < total; t++) begin
      b = t / 8;
      k = 7 - (t % 8);
      rx_full = (mode == 0) ? m_drop[b] : 1'b0;
      mosi = m_bytes[b][k];
      wait_clk(4);
      if (k == 7) check_eq("miso_oe_active", {31'd0, miso_oe}, 1);
      got[k] = miso;
      sck = 1'b1;
      if (k == 0 && mode == 0 && !m_drop[b]) rise_cyc_q.push_back(cyc);
      wait_clk(4);
      sck = 1'b0;
      // Final trailing edge coincides with cs release: cs must win.
      if (mode == 0 && t == total - 1) cs = 1'b1;
      if (k == 0) begin
        check_eq("miso_byte", {24'd0, got},
                 {24'd0, (b < ntx) ? tx_vals[b] : IDLE});
        $display("[TB] byte %0d mosi=%02h miso=%02h drop=%0d", b, m_bytes[b], got, m_drop[b]);
      end
    end
    if (mode == 2) begin
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      cs = 1'b1;
      sck = 1'b0;
      wait_clk(3);
      check_reset_outputs("rst_hold");
      rst_n = 1'b1;
    end else begin
      cs = 1'b1;
      wait_clk(SYNC + 2);
      check_eq("end_busy",    {31'd0, busy}, 0);
      check_eq("end_miso_oe", {31'd0, miso_oe}, 0);
    end
    rx_full = 1'b0;
    wait_clk(10);
    check_eq("tx_rd_count", tx_rd_cnt - rd0, exp_rd);
    check_eq("rx_wr_count", rx_wr_cnt - wr0, exp_wr);
    check_eq("rx_pending",  exp_rx_q.size(), 0);
    check_eq("underrun",    {31'd0, underrun}, {31'd0, exp_ur});
    check_eq("overrun",     {31'd0, overrun}, {31'd0, exp_or});
    $display("[TB] frame mode=%0d bytes=%0d tx=%0d done", mode, nb, ntx);
    exp_rx_q.delete();
    rise_cyc_q.delete();
  endtask

  initial begin
    int nb, ntx;
    rst_n = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    din = 8'h00; tx_empty = 1'b1; rx_full = 1'b0; clr_err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_bytes[i] = 8'h00; m_drop[i] = 1'b0; tx_vals[i] = 8'h00;
    end
    wait_clk(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_clk(4);

    m_bytes[0] = 8'h3C; tx_vals[0] = 8'hA5;
    run_frame(1, 1, 0, 0);

    m_bytes[0] = 8'h01; m_bytes[1] = 8'h02; m_bytes[2] = 8'h03;
    tx_vals[0] = 8'h10; tx_vals[1] = 8'h20; tx_vals[2] = 8'h30; tx_vals[3] = 8'h40;
    run_frame(3, 4, 0, 0);

    m_bytes[0] = 8'h5A;
    run_frame(1, 0, 0, 0);
    pulse_clr();

    m_bytes[0] = 8'hC3; m_bytes[1] = 8'h96; m_drop[0] = 1'b1;
    tx_vals[0] = 8'h11; tx_vals[1] = 8'h22;
    run_frame(2, 2, 0, 0);
    m_drop[0] = 1'b0;
    pulse_clr();

    m_bytes[0] = 8'hE7; tx_vals[0] = 8'h81;
    run_frame(1, 1, 1, 5);
    m_bytes[0] = 8'h42; tx_vals[0] = 8'h24;
    run_frame(1, 1, 0, 0);

    m_bytes[0] = 8'hB1; tx_vals[0] = 8'h7E;
    run_frame(1, 2, 2, 3);
    m_bytes[0] = 8'h69; tx_vals[0] = 8'h9C;
    run_frame(1, 1, 0, 0);

    for (int f = 0; f < 16; f++) begin
      nb  = $urandom_range(1, 4);
      ntx = $urandom_range(0, nb + 1);
      for (int i = 0; i < 8; i++) begin
        m_bytes[i] = 8'($urandom);
        tx_vals[i] = 8'($urandom);
        m_drop[i]  = ($urandom_range(0, 3) == 0);
      end
      pulse_clr();
      run_frame(nb, ntx, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
